// File: rtl/ppu_defines.sv
// Shared PPU types: secondary OAM entry, pattern table select,
// sprite evaluator state encoding and sprite heights.
package ppu_defines;

  typedef enum logic {
    PT_LEFT  = 1'b0,
    PT_RIGHT = 1'b1
  } pattern_tbl_t;

  typedef struct packed {
    logic       active;
    logic [7:0] y;
    logic [7:0] tile;
    logic [7:0] attr;
    logic [7:0] x;
    logic [7:0] bitmap_lo;
    logic [7:0] bitmap_hi;
  } second_oam_t;

  typedef enum logic [2:0] {
    IDLE,
    EV_Y,
    EV_TILE,
    EV_ATTR,
    EV_X,
    FETCH,
    DONE
  } sp_eval_state_t;

  localparam int SPR_H_SHORT = 8;
  localparam int SPR_H_TALL  = 16;

endpackage

// File: rtl/sp_eval_gen_chr_addr.sv
// sp_chr_addr: combinational sprite pattern address generator.
// Ports: row/y low nibbles, tile, vflip, tall, table -> lo/hi plane addr.
module sp_chr_addr
  import ppu_defines::*;
(
  input  logic [3:0]   row_lo,
  input  logic [3:0]   y_lo,
  input  logic [7:0]   tile,
  input  logic         flip,
  input  logic         tall,
  input  pattern_tbl_t patt,
  output logic [12:0]  addr_lo,
  output logic [12:0]  addr_hi
);

  logic [3:0] r;
  logic [3:0] rf;

  always_comb begin
    r  = row_lo - y_lo;
    rf = r;
    if (flip) begin
      if (tall)
        rf = 4'(SPR_H_TALL - 1) - r;
      else
        rf = {1'b0, 3'(SPR_H_SHORT - 1) - r[2:0]};
    end
    // 8x16: tile bit 0 picks the table, row bit 3 picks the half
    if (tall)
      addr_lo = {tile[0], tile[7:1], rf[3], 1'b0, rf[2:0]};
    else
      addr_lo = {patt == PT_RIGHT, tile, 1'b0, rf[2:0]};
    // bit 3 is always clear, so +8 is an OR
    addr_hi = addr_lo | 13'h008;
  end

endmodule

// File: rtl/sp_eval_gen.sv
// Per-scanline sprite evaluator: scans primary OAM, buffers in-range
// sprites, then fetches patterns and writes every secondary OAM slot.
module sp_eval_gen
  import ppu_defines::*;
#(
  parameter  int NUM_OAM = 64,
  parameter  int MAX_SPR = 8,
  localparam int SW = $clog2(MAX_SPR),
  localparam int CW = $clog2(MAX_SPR + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clk_en,
  input  logic          eval_start,
  input  logic [8:0]    scan_row,
  input  logic          spr_tall,
  input  pattern_tbl_t  patt_tbl,
  output logic [7:0]    oam_addr,
  input  logic [7:0]    oam_data,
  output logic          sec_wr,
  output logic [SW-1:0] sec_wr_idx,
  output second_oam_t   sec_wr_data,
  output logic          chr_re,
  output logic [12:0]   chr_addr_lo,
  output logic [12:0]   chr_addr_hi,
  input  logic [7:0]    chr_data_lo,
  input  logic [7:0]    chr_data_hi,
  output logic [CW-1:0] spr_count,
  output logic          spr_overflow,
  output logic          spr0_on_line,
  output logic          busy,
  output logic          done
);

  localparam int NW = $clog2(NUM_OAM);

  sp_eval_state_t state, state_d;

  logic [NW-1:0] n;
  logic [CW-1:0] cnt;
  logic [SW-1:0] s;
  logic [8:0]    row_q;
  logic          tall_q;
  pattern_tbl_t  patt_q;
  logic [7:0]    y_q;
  logic [7:0]    tile_q;
  logic [7:0]    attr_q;
  logic          ovf_q;
  logic          spr0_q;
  second_oam_t   slot_q [MAX_SPR];

  logic [8:0]  d;
  logic        in_rng;
  logic        full;
  logic        n_last;
  logic        s_last;
  logic        fetch;
  logic        s_act;
  logic [1:0]  k;
  logic [12:0] a_lo;
  logic [12:0] a_hi;

  // unsigned wrap makes sprites below the row fail the test
  assign d      = row_q - {1'b0, oam_data};
  assign in_rng = d < (tall_q ? 9'(SPR_H_TALL)
                              : 9'(SPR_H_SHORT));
  assign full   = cnt == CW'(MAX_SPR);
  assign n_last = n == NW'(NUM_OAM - 1);
  assign s_last = s == SW'(MAX_SPR - 1);
  assign fetch  = state == FETCH;
  assign s_act  = fetch && (CW'(s) < cnt);

  always_comb begin
    k = 2'd0;
    unique case (state)
      EV_TILE: k = 2'd1;
      EV_ATTR: k = 2'd2;
      EV_X:    k = 2'd3;
      default: k = 2'd0;
    endcase
  end

  assign oam_addr = 8'({n, k});

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (eval_start) state_d = EV_Y;
      EV_Y: begin
        if (in_rng)
          state_d = full ? FETCH : EV_TILE;
        else if (n_last)
          state_d = FETCH;
      end
      EV_TILE: state_d = EV_ATTR;
      EV_ATTR: state_d = EV_X;
      EV_X:    state_d = n_last ? FETCH : EV_Y;
      FETCH:   if (s_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // a new request always wins, aborting any pass
    if (eval_start) state_d = EV_Y;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else if (clk_en)
      state <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n      <= '0;
      cnt    <= '0;
      s      <= '0;
      row_q  <= '0;
      tall_q <= 1'b0;
      patt_q <= PT_LEFT;
      y_q    <= '0;
      tile_q <= '0;
      attr_q <= '0;
      ovf_q  <= 1'b0;
      spr0_q <= 1'b0;
      for (int i = 0; i < MAX_SPR; i++)
        slot_q[i] <= '0;
    end else if (clk_en) begin
      if (eval_start) begin
        n      <= '0;
        cnt    <= '0;
        s      <= '0;
        ovf_q  <= 1'b0;
        spr0_q <= 1'b0;
        row_q  <= scan_row;
        tall_q <= spr_tall;
        patt_q <= patt_tbl;
      end else begin
        unique case (state)
          EV_Y: begin
            if (in_rng) begin
              if (n == '0) spr0_q <= 1'b1;
              if (full) ovf_q <= 1'b1;
              else      y_q   <= oam_data;
            end else begin
              n <= n + 1'b1;
            end
          end
          EV_TILE: tile_q <= oam_data;
          EV_ATTR: attr_q <= oam_data;
          EV_X: begin
            slot_q[cnt[SW-1:0]] <= '{
              active:    1'b1,
              y:         y_q,
              tile:      tile_q,
              attr:      attr_q,
              x:         oam_data,
              bitmap_lo: 8'h00,
              bitmap_hi: 8'h00
            };
            cnt <= cnt + 1'b1;
            n   <= n + 1'b1;
          end
          FETCH: s <= s_last ? '0 : s + 1'b1;
          default: ;
        endcase
      end
    end
  end

  sp_chr_addr u_addr (
    .row_lo  (row_q[3:0]),
    .y_lo    (slot_q[s].y[3:0]),
    .tile    (slot_q[s].tile),
    .flip    (slot_q[s].attr[7]),
    .tall    (tall_q),
    .patt    (patt_q),
    .addr_lo (a_lo),
    .addr_hi (a_hi)
  );

  always_comb begin
    sec_wr_data = '0;
    if (s_act) begin
      sec_wr_data           = slot_q[s];
      sec_wr_data.bitmap_lo = chr_data_lo;
      sec_wr_data.bitmap_hi = chr_data_hi;
    end
  end

  assign sec_wr       = fetch;
  assign sec_wr_idx   = fetch ? s : '0;
  assign chr_re       = s_act;
  assign chr_addr_lo  = s_act ? a_lo : '0;
  assign chr_addr_hi  = s_act ? a_hi : '0;
  assign spr_count    = cnt;
  assign spr_overflow = ovf_q;
  assign spr0_on_line = spr0_q;
  assign busy         = state != IDLE;
  assign done         = state == DONE;

endmodule

// File: tb/tb_sp_eval_gen.sv
// Testbench for sp_eval_gen: OAM/CHR memory models and a queue of
// expected secondary OAM writes built from a reference model.
module tb_sp_eval_gen;
  import ppu_defines::*;

  localparam int MAX_SPR = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clk_en = 1'b0;
  logic eval_start = 1'b0;
  logic spr_tall = 1'b0;
  logic [8:0] scan_row = '0;
  pattern_tbl_t patt_tbl = PT_LEFT;
  logic [7:0] oam_addr, oam_data;
  logic [7:0] chr_data_lo, chr_data_hi;
  logic sec_wr, chr_re;
  logic [2:0] sec_wr_idx;
  second_oam_t sec_wr_data;
  logic [12:0] chr_addr_lo, chr_addr_hi;
  logic [3:0] spr_count;
  logic spr_overflow, spr0_on_line, busy, done;

  logic [7:0] oam [256];

  typedef struct {
    logic [2:0]  idx;
    second_oam_t data;
    logic        re;
    logic [12:0] lo;
    logic [12:0] hi;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int n_chk = 0;
  int n_fail = 0;
  int done_cnt = 0;
  logic [7:0] last_addr;
  logic [12:0] first_lo, first_hi;
  int exp_cnt;
  bit exp_ovf, exp_spr0;

  sp_eval_gen dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clk_en       (clk_en),
    .eval_start   (eval_start),
    .scan_row     (scan_row),
    .spr_tall     (spr_tall),
    .patt_tbl     (patt_tbl),
    .oam_addr     (oam_addr),
    .oam_data     (oam_data),
    .sec_wr       (sec_wr),
    .sec_wr_idx   (sec_wr_idx),
    .sec_wr_data  (sec_wr_data),
    .chr_re       (chr_re),
    .chr_addr_lo  (chr_addr_lo),
    .chr_addr_hi  (chr_addr_hi),
    .chr_data_lo  (chr_data_lo),
    .chr_data_hi  (chr_data_hi),
    .spr_count    (spr_count),
    .spr_overflow (spr_overflow),
    .spr0_on_line (spr0_on_line),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  assign oam_data    = oam[oam_addr];
  assign chr_data_lo = chr_addr_lo[7:0] ^ 8'h5A;
  assign chr_data_hi = chr_addr_hi[7:0] ^ 8'hA5;

  initial begin
    int c;
    c = 0;
    forever begin
      @(posedge clk);
      #1;
      c++;
      clk_en = (c % 4 == 0);
    end
  end

  task automatic chk(string tag, logic [63:0] got,
                     logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && clk_en) begin
      if (sec_wr) begin
        if (sb.size() == 0) begin
          chk("sb_empty", 1, 0);
        end else begin
          me = sb.pop_front();
          chk("wr_idx", 64'(sec_wr_idx), 64'(me.idx));
          chk("wr_data", 64'(sec_wr_data), 64'(me.data));
          chk("chr_re", 64'(chr_re), 64'(me.re));
          if (me.re) begin
            chk("chr_lo", 64'(chr_addr_lo), 64'(me.lo));
            chk("chr_hi", 64'(chr_addr_hi), 64'(me.hi));
          end
          if (sec_wr_idx == 3'd0) begin
            first_lo = chr_addr_lo;
            first_hi = chr_addr_hi;
          end
        end
      end else if (busy && !done) begin
        last_addr = oam_addr;
      end
      if (done) done_cnt++;
    end
  end

  task automatic build_exp();
    int cnt;
    int h;
    logic [8:0] d;
    logic [7:0] ys [MAX_SPR];
    logic [7:0] ts [MAX_SPR];
    logic [7:0] as [MAX_SPR];
    logic [7:0] xs [MAX_SPR];
    cnt = 0;
    h = spr_tall ? 16 : 8;
    exp_ovf = 0;
    exp_spr0 = 0;
    for (int n = 0; n < 64; n++) begin
      d = scan_row - {1'b0, oam[4*n]};
      if (int'(d) < h) begin
        if (n == 0) exp_spr0 = 1;
        if (cnt == MAX_SPR) begin
          exp_ovf = 1;
          break;
        end
        ys[cnt] = oam[4*n];
        ts[cnt] = oam[4*n+1];
        as[cnt] = oam[4*n+2];
        xs[cnt] = oam[4*n+3];
        cnt++;
      end
    end
    exp_cnt = cnt;
    for (int s = 0; s < MAX_SPR; s++) begin
      exp_t x;
      int r, rf, addr, tl;
      x.idx = 3'(s);
      x.data = '0;
      x.re = 0;
      x.lo = '0;
      x.hi = '0;
      if (s < cnt) begin
        r = (int'(scan_row) - int'(ys[s])) & 15;
        rf = as[s][7] ? (h - 1 - r) : r;
        if (spr_tall) begin
          tl = (int'(ts[s]) & 'hFE) + rf / 8;
          addr = (int'(ts[s]) & 1) * 4096 + tl * 16 + rf % 8;
        end else begin
          addr = (patt_tbl == PT_RIGHT ? 4096 : 0)
                 + int'(ts[s]) * 16 + rf % 8;
        end
        x.re = 1;
        x.lo = 13'(addr);
        x.hi = 13'(addr + 8);
        x.data.active = 1'b1;
        x.data.y = ys[s];
        x.data.tile = ts[s];
        x.data.attr = as[s];
        x.data.x = xs[s];
        x.data.bitmap_lo = x.lo[7:0] ^ 8'h5A;
        x.data.bitmap_hi = x.hi[7:0] ^ 8'hA5;
      end
      sb.push_back(x);
    end
  endtask

  task automatic wait_en();
    do @(negedge clk); while (!clk_en);
  endtask

  task automatic pulse_start();
    wait_en();
    eval_start = 1'b1;
    @(negedge clk);
    eval_start = 1'b0;
  endtask

  task automatic wait_done(string tag);
    bit got;
    got = 0;
    for (int i = 0; i < 8000 && !got; i++) begin
      @(negedge clk);
      if (clk_en && done) got = 1;
    end
    chk({tag, "_done"}, 64'(got), 1);
  endtask

  task automatic run_eval(string tag);
    build_exp();
    last_addr = 8'hFF;
    pulse_start();
    wait_done(tag);
    chk({tag, "_cnt"}, 64'(spr_count), 64'(exp_cnt));
    chk({tag, "_ovf"}, 64'(spr_overflow), 64'(exp_ovf));
    chk({tag, "_spr0"}, 64'(spr0_on_line), 64'(exp_spr0));
    chk({tag, "_sb"}, 64'(sb.size()), 0);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_wr"}, 64'(sec_wr), 0);
    chk({tag, "_re"}, 64'(chr_re), 0);
    chk({tag, "_data"}, 64'(sec_wr_data), 0);
    chk({tag, "_alo"}, 64'(chr_addr_lo), 0);
    chk({tag, "_ahi"}, 64'(chr_addr_hi), 0);
    chk({tag, "_oam"}, 64'(oam_addr), 0);
    chk({tag, "_cnt"}, 64'(spr_count), 0);
    chk({tag, "_ovf"}, 64'(spr_overflow), 0);
    chk({tag, "_s0"}, 64'(spr0_on_line), 0);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_done"}, 64'(done), 0);
  endtask

  task automatic clear_oam();
    for (int i = 0; i < 256; i++)
      oam[i] = ((i % 4) == 0) ? 8'hEF : 8'(i * 7 + 3);
  endtask

  task automatic set_spr(int i, logic [7:0] y, logic [7:0] t,
                         logic [7:0] a, logic [7:0] x);
    oam[4*i]   = y;
    oam[4*i+1] = t;
    oam[4*i+2] = a;
    oam[4*i+3] = x;
  endtask

  initial begin
    int d0, pre;
    bit hit;
    clear_oam();
    scan_row = 9'h055;
    #23;
    chk_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // single sprite 0, 8x8 left table
    scan_row = 9'd20;
    spr_tall = 1'b0;
    patt_tbl = PT_LEFT;
    set_spr(0, 8'd15, 8'h33, 8'h41, 8'h50);
    run_eval("one");
    chk("one_addr", 64'(first_lo), 64'(13'h0335));

    // counters hold after done
    repeat (8) wait_en();
    chk("hold_cnt", 64'(spr_count), 1);
    chk("hold_s0", 64'(spr0_on_line), 1);
    chk("hold_busy", 64'(busy), 0);

    // nine sprites on the row: overflow, fetch right after Y of #8
    clear_oam();
    for (int i = 0; i < 9; i++)
      set_spr(i, 8'd10, 8'(8'h10 + i), 8'(i * 8'h21), 8'(i * 9));
    scan_row = 9'd12;
    patt_tbl = PT_RIGHT;
    run_eval("ovf");
    chk("ovf_last_y", 64'(last_addr), 64'd32);

    // 8x16, no flip, sprite not at index 0
    clear_oam();
    set_spr(3, 8'd100, 8'h25, 8'h00, 8'h80);
    scan_row = 9'd110;
    spr_tall = 1'b1;
    patt_tbl = PT_LEFT;
    run_eval("tall");
    chk("tall_lo", 64'(first_lo), 64'(13'h1252));
    chk("tall_hi", 64'(first_hi), 64'(13'h125A));

    // same sprite, vertical flip
    oam[14] = 8'h80;
    run_eval("flip");
    chk("flip_lo", 64'(first_lo), 64'(13'h1245));

    // in-range boundaries: d = H-1 in, d = H out
    clear_oam();
    scan_row = 9'd40;
    spr_tall = 1'b0;
    set_spr(0, 8'd33, 8'h01, 8'h80, 8'h11);
    set_spr(1, 8'd32, 8'h02, 8'h00, 8'h22);
    set_spr(2, 8'd40, 8'h03, 8'h00, 8'h33);
    set_spr(3, 8'd41, 8'h04, 8'h00, 8'h44);
    run_eval("bnd8");
    spr_tall = 1'b1;
    set_spr(1, 8'd24, 8'h05, 8'h80, 8'h55);
    set_spr(4, 8'd25, 8'h06, 8'h80, 8'h66);
    run_eval("bnd16");

    // random tables near the row
    for (int it = 0; it < 4; it++) begin
      scan_row = 9'($urandom_range(0, 239));
      spr_tall = it[0];
      patt_tbl = pattern_tbl_t'(it[1]);
      for (int i = 0; i < 64; i++) begin
        d0 = int'($urandom_range(0, 18));
        if ($urandom_range(0, 3) == 0)
          oam[4*i] = 8'(int'(scan_row) - d0);
        else
          oam[4*i] = 8'($urandom_range(0, 255));
        oam[4*i+1] = 8'($urandom);
        oam[4*i+2] = 8'($urandom);
        oam[4*i+3] = 8'($urandom);
      end
      run_eval("rnd");
    end

    // abort during EV_ATTR of sprite 1
    clear_oam();
    scan_row = 9'd50;
    spr_tall = 1'b0;
    set_spr(0, 8'd45, 8'h07, 8'h00, 8'h01);
    set_spr(1, 8'd46, 8'h08, 8'h80, 8'h02);
    pulse_start();
    hit = 0;
    for (int i = 0; i < 400 && !hit; i++) begin
      wait_en();
      if (oam_addr == 8'd6) hit = 1;
    end
    chk("abort_seen", 64'(hit), 1);
    pre = done_cnt;
    build_exp();
    eval_start = 1'b1;
    @(negedge clk);
    eval_start = 1'b0;
    wait_en();
    chk("abort_cnt", 64'(spr_count), 0);
    chk("abort_oam", 64'(oam_addr), 0);
    wait_done("abort");
    chk("abort_sb", 64'(sb.size()), 0);
    repeat (3) wait_en();
    chk("abort_ndone", 64'(done_cnt - pre), 1);

    // reset in the middle of FETCH
    build_exp();
    pulse_start();
    hit = 0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      wait_en();
      if (sec_wr) hit = 1;
    end
    chk("frst_seen", 64'(hit), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_zero("frst");
    sb.delete();
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    hit = 0;
    repeat (60) begin
      @(negedge clk);
      if (sec_wr || busy) hit = 1;
    end
    chk("frst_quiet", 64'(hit), 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/sp_eval_gen.md
SP_EVAL_GEN -- requirements
Module: sp_eval_gen

Interface
REQ-001 Parameter NUM_OAM, default 64: number of primary OAM entries, 4 bytes each, evaluated per scanline.
REQ-002 Parameter MAX_SPR, default 8: secondary OAM slots; SW = $clog2(MAX_SPR), CW = $clog2(MAX_SPR+1).
REQ-003 clk  input  1  master clock; the block has one clock; all state advances only when clk_en=1.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 clk_en  input  1  PPU-rate enable (master/4).
REQ-006 eval_start  input  1  one-cycle (qualified by clk_en) request to evaluate scan_row.
REQ-007 scan_row  input  9  scanline whose sprites are gathered.
REQ-008 spr_tall  input  1  0 = 8x8 sprites, 1 = 8x16 sprites; sampled at eval_start.
REQ-009 patt_tbl  input  pattern_tbl_t  sprite table in 8x8 mode; sampled at eval_start.
REQ-010 oam_addr  output  8  primary OAM byte address; oam_data valid the same cycle.
REQ-011 oam_data  input  8  primary OAM read data.
REQ-012 sec_wr / sec_wr_idx / sec_wr_data  output  1 / SW / second_oam_t  secondary OAM write port.
REQ-013 chr_re, chr_addr_lo, chr_addr_hi  output  1, 13, 13  pattern fetch; hi = lo + 8.
REQ-014 chr_data_lo, chr_data_hi  input  8 each  pattern bytes, valid the same cycle.
REQ-015 spr_count  output  CW  number of in-range sprites stored, saturating at MAX_SPR.
REQ-016 spr_overflow, spr0_on_line, busy, done  output  1 each  status; done is a one-enabled-cycle pulse.

Function
REQ-017 FSM states: IDLE, EV_Y, EV_TILE, EV_ATTR, EV_X, FETCH, DONE; transitions occur only on clk_en.
REQ-018 IDLE: eval_start moves to EV_Y with n=0, count=0, and clears spr_overflow and spr0_on_line.
REQ-019 oam_addr = 4n + k, with k = 0/1/2/3 in EV_Y/EV_TILE/EV_ATTR/EV_X.
REQ-020 In-range test: d = scan_row - {1'b0, oam_data} (9-bit unsigned); in range iff d < H, where H = 16 if tall, else 8.
REQ-021 EV_Y, not in range: n increments and the state stays EV_Y; after n = NUM_OAM-1 the FSM goes to FETCH.
REQ-022 EV_Y, in range, count < MAX_SPR: y is latched, then the FSM steps through EV_TILE, EV_ATTR and EV_X, latching one byte each.
REQ-023 EV_X: the entry is stored in internal temp buffer slot[count] with active=1; count increments; n increments; the FSM returns to EV_Y, or goes to FETCH if n was last.
REQ-024 EV_Y, in range with n = 0: spr0_on_line is set.
REQ-025 EV_Y, in range, count == MAX_SPR: spr_overflow is set and the FSM goes directly to FETCH.
REQ-026 FETCH: exactly MAX_SPR enabled cycles, slot s = 0..MAX_SPR-1, with sec_wr=1 and sec_wr_idx=s.
REQ-027 FETCH, s < count: chr_re=1 and sec_wr_data = buffered entry plus bitmap_lo = chr_data_lo, bitmap_hi = chr_data_hi.
REQ-028 FETCH, s >= count: sec_wr_data = all zeros (active=0) and chr_re=0.
REQ-029 Row in sprite r = scan_row - y (4 bits); vertical flip is attribute[7]: r' = (H-1) - r when set, else r' = r.
REQ-030 8x8 address: table base (LEFT 0x0000, RIGHT 0x1000) + {tile, 1'b0, r'[2:0]}.
REQ-031 8x16 address: table base = tile[0] ? 0x1000 : 0x0000; tile' = {tile[7:1], r'[3]}; address = base + {tile', 1'b0, r'[2:0]}.
REQ-032 No horizontal flip is applied here; attribute[6] is passed through to the renderer.
REQ-033 After FETCH the FSM enters DONE: done=1 for one enabled cycle, then IDLE.
REQ-034 busy=1 in every state except IDLE.
REQ-035 eval_start in any non-IDLE state aborts the evaluation and restarts per REQ-018; no DONE pulse is issued for the aborted pass.
REQ-036 spr_count, spr_overflow and spr0_on_line hold their values from DONE until the next eval_start.
REQ-037 Outside FETCH: sec_wr=0 and chr_re=0.

Reset
REQ-038 On rst_n=0, asynchronously: state=IDLE, n=0, count=0, temp buffer zeroed, and all outputs 0.
REQ-039 Reset asserted mid-evaluation discards all progress; no partial secondary OAM writes follow the reset.

Structure
REQ-040 ppu_defines package additions: sp_eval_state_t enum, SPR_H_SHORT=8, SPR_H_TALL=16; second_oam_t and pattern_tbl_t are reused unchanged.
REQ-041 Pattern address generation (REQ-029..031) is a combinational sub-module, sp_chr_addr.

Verification
REQ-042 8x8, scan_row=20, sprite0 y=15, all other y=0xEF -> one slot filled; spr_count=1, spr0_on_line=1, no overflow; addr = tile*16+5; slots 1..7 written active=0.
REQ-043 9 sprites at y=10, scan_row=12 -> slots 0..7 hold sprites 0..7; spr_overflow=1; the FSM enters FETCH right after sprite 8's Y byte.
REQ-044 8x16, tile=0x25, y=100, scan_row=110, flip=0 -> chr_addr_lo=0x1000+0x25*16+2=0x1252 and chr_addr_hi=0x125A.
REQ-045 8x16, same sprite with attribute[7]=1 -> r'=5, tile'=0x24, chr_addr_lo=0x1245.
REQ-046 eval_start re-pulsed during EV_ATTR -> count restarts at 0, no done for the first pass; rst_n dropped in FETCH -> all outputs 0 immediately.
